// File: rtl/tqvp_pulse_generator.sv
// TinyQV user peripheral: programmable burst of pulses on masked uo_out pins.
// Optional external trigger on ui_in[0] is built when PULSE_GEN_TRIGGER_EN is defined.
module tqvp_pulse_generator #(
    parameter logic [3:0] ADDR_CTRL   = 4'h0,
    parameter logic [3:0] ADDR_COUNT  = 4'h1,
    parameter logic [3:0] ADDR_HIGH   = 4'h2,
    parameter logic [3:0] ADDR_LOW    = 4'h3,
    parameter logic [3:0] ADDR_PINS   = 4'h4,
    parameter logic [3:0] ADDR_REMAIN = 4'h5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q, high_q, low_q, pins_q;
    logic [7:0] high_sh_q, high_sh_d;
    logic [7:0] low_sh_q, low_sh_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] remain_q, remain_d;
    logic       pol_q, pol_d;
    logic       trig_en_q;
    logic       done_q, done_d;
    logic [7:0] pins_d;
    logic [7:0] uo_d;
    logic       busy;

    logic wr_ctrl, wr_count, wr_high, wr_low, wr_pins;
    logic cmd_start, cmd_stop, cmd_clr_done;
    logic trig_start, start_req;
    logic unused_ui;

    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    assign wr_ctrl  = data_write && (address == ADDR_CTRL);
    assign wr_count = data_write && (address == ADDR_COUNT);
    assign wr_high  = data_write && (address == ADDR_HIGH);
    assign wr_low   = data_write && (address == ADDR_LOW);
    assign wr_pins  = data_write && (address == ADDR_PINS);

    assign cmd_start    = wr_ctrl && data_in[0];
    assign cmd_stop     = wr_ctrl && data_in[1];
    assign cmd_clr_done = wr_ctrl && data_in[4];

    assign busy      = (state_q != ST_IDLE);
    assign unused_ui = ^ui_in;

`ifdef PULSE_GEN_TRIGGER_EN
    // Two-flop synchronizer plus a third flop for rising-edge detection.
    logic sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            trig_en_q <= 1'b0;
        end else begin
            sync1_q <= ui_in[0];
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (wr_ctrl) trig_en_q <= data_in[3];
        end
    end

    assign trig_start = trig_en_q && sync2_q && !sync3_q;
`else
    assign trig_en_q  = 1'b0;
    assign trig_start = 1'b0;
`endif

    assign start_req = cmd_start || trig_start;

    // Configuration registers; shadow copies isolate the running burst from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
            high_q  <= 8'd0;
            low_q   <= 8'd0;
            pins_q  <= 8'h01;
        end else begin
            if (wr_count) count_q <= data_in;
            if (wr_high)  high_q  <= data_in;
            if (wr_low)   low_q   <= data_in;
            if (wr_pins)  pins_q  <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            high_sh_q <= 8'd0;
            low_sh_q  <= 8'd0;
            phase_q   <= 8'd0;
            remain_q  <= 8'd0;
            pol_q     <= 1'b0;
            done_q    <= 1'b0;
            uo_out    <= 8'h00;
        end else begin
            state_q   <= state_d;
            high_sh_q <= high_sh_d;
            low_sh_q  <= low_sh_d;
            phase_q   <= phase_d;
            remain_q  <= remain_d;
            pol_q     <= pol_d;
            done_q    <= done_d;
            uo_out    <= uo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        high_sh_d = high_sh_q;
        low_sh_d  = low_sh_q;
        phase_d   = phase_q;
        remain_d  = remain_q;
        done_d    = done_q;

        if (cmd_clr_done) done_d = 1'b0;

        // STOP is checked first so it overrides START or a trigger in any state.
        if (cmd_stop) begin
            state_d  = ST_IDLE;
            remain_d = 8'd0;
            phase_d  = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req && (count_q != 8'd0)) begin
                        state_d   = ST_HIGH;
                        remain_d  = count_q;
                        high_sh_d = high_q;
                        low_sh_d  = low_q;
                        phase_d   = at_least_one(high_q);
                        done_d    = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (phase_q <= 8'd1) begin
                        state_d = ST_LOW;
                        phase_d = at_least_one(low_sh_q);
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
                ST_LOW: begin
                    if (phase_q <= 8'd1) begin
                        if (remain_q > 8'd1) begin
                            state_d  = ST_HIGH;
                            remain_d = remain_q - 8'd1;
                            phase_d  = at_least_one(high_sh_q);
                        end else begin
                            state_d  = ST_IDLE;
                            remain_d = 8'd0;
                            phase_d  = 8'd0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = 8'd0;
                    phase_d  = 8'd0;
                end
            endcase
        end
    end

    // Output register is fed from next-cycle values so PINS/POL writes land on the next edge.
    always_comb begin
        pol_d  = wr_ctrl ? data_in[2] : pol_q;
        pins_d = wr_pins ? data_in : pins_q;
        uo_d   = pins_d & {8{(state_d == ST_HIGH) ^ pol_d}};
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = {busy, done_q, 2'b00, trig_en_q, pol_q, 2'b00};
            ADDR_COUNT:  data_out = count_q;
            ADDR_HIGH:   data_out = high_q;
            ADDR_LOW:    data_out = low_q;
            ADDR_PINS:   data_out = pins_q;
            ADDR_REMAIN: data_out = remain_q;
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_pulse_generator.sv
// Directed bench for tqvp_pulse_generator: single pulse, masked burst, abort,
// polarity, boundary cases, async reset and (when built in) the external trigger.
module tb_tqvp_pulse_generator;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_checks;
    int n_fails;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_COUNT  = 4'h1;
    localparam logic [3:0] A_HIGH   = 4'h2;
    localparam logic [3:0] A_LOW    = 4'h3;
    localparam logic [3:0] A_PINS   = 4'h4;
    localparam logic [3:0] A_REMAIN = 4'h5;

    tqvp_pulse_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 ns after the edge that sampled the write.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;

        // Reset state
        #23;
        check("rst_uo", uo_out, 8'h00);
        check_rd("rst_ctrl", A_CTRL, 8'h00);
        check_rd("rst_pins", A_PINS, 8'h01);
        check_rd("rst_count", A_COUNT, 8'h00);
        check_rd("rst_remain", A_REMAIN, 8'h00);
        rst_n = 1'b1;
        step(1);

        // Single pulse: 2 high, 3 low
        wr(A_COUNT, 8'd1);
        wr(A_HIGH, 8'd2);
        wr(A_LOW, 8'd3);
        wr(A_CTRL, 8'h01);
        check("sp_e0_uo", uo_out, 8'h01);
        check_rd("sp_e0_busy", A_CTRL, 8'h80);
        check_rd("sp_e0_remain", A_REMAIN, 8'h01);
        step(1);
        check("sp_e1_uo", uo_out, 8'h01);
        step(1);
        check("sp_e2_uo", uo_out, 8'h00);
        step(2);
        check("sp_e4_uo", uo_out, 8'h00);
        check_rd("sp_e4_busy", A_CTRL, 8'h80);
        step(1);
        check("sp_e5_uo", uo_out, 8'h00);
        check_rd("sp_e5_done", A_CTRL, 8'h40);
        check_rd("sp_e5_remain", A_REMAIN, 8'h00);

        wr(A_CTRL, 8'h10);
        check_rd("clr_done", A_CTRL, 8'h00);

        // Burst of 4 minimum-length pulses on a mask
        wr(A_PINS, 8'hA5);
        check("mask_idle_uo", uo_out, 8'h00);
        wr(A_COUNT, 8'd4);
        wr(A_HIGH, 8'd0);
        wr(A_LOW, 8'd0);
        wr(A_CTRL, 8'h01);
        check_rd("burst_remain0", A_REMAIN, 8'h04);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("burst_uo_%0d", i), uo_out, (i % 2 == 0) ? 8'hA5 : 8'h00);
            if (i == 7) check_rd("burst_busy_last", A_CTRL, 8'h80);
            step(1);
        end
        check("burst_end_uo", uo_out, 8'h00);
        check_rd("burst_end_ctrl", A_CTRL, 8'h40);

        // Abort mid-burst with START+STOP in one write
        wr(A_PINS, 8'h01);
        wr(A_COUNT, 8'd10);
        wr(A_HIGH, 8'd5);
        wr(A_LOW, 8'd5);
        wr(A_CTRL, 8'h01);
        check_rd("abort_done_cleared", A_CTRL, 8'h80);
        step(11);
        check("abort_e11_uo", uo_out, 8'h01);
        check_rd("abort_e11_remain", A_REMAIN, 8'd9);
        wr(A_CTRL, 8'h03);
        check("abort_uo", uo_out, 8'h00);
        check_rd("abort_ctrl", A_CTRL, 8'h00);
        check_rd("abort_remain", A_REMAIN, 8'h00);
        step(2);
        check("abort_stay_uo", uo_out, 8'h00);
        check_rd("abort_stay_ctrl", A_CTRL, 8'h00);

        // Inverted polarity and a COUNT write during the burst
        wr(A_CTRL, 8'h04);
        check("pol_idle_uo", uo_out, 8'h01);
        wr(A_COUNT, 8'd2);
        wr(A_HIGH, 8'd1);
        wr(A_LOW, 8'd2);
        wr(A_CTRL, 8'h05);
        check("pol_e0_uo", uo_out, 8'h00);
        check_rd("pol_e0_ctrl", A_CTRL, 8'h84);
        wr(A_COUNT, 8'd7);
        check("pol_e1_uo", uo_out, 8'h01);
        check_rd("pol_count_rd", A_COUNT, 8'd7);
        step(1);
        check("pol_e2_uo", uo_out, 8'h01);
        step(1);
        check("pol_e3_uo", uo_out, 8'h00);
        step(1);
        check("pol_e4_uo", uo_out, 8'h01);
        step(1);
        check_rd("pol_e5_ctrl", A_CTRL, 8'h84);
        step(1);
        check("pol_e6_uo", uo_out, 8'h01);
        check_rd("pol_e6_ctrl", A_CTRL, 8'h44);

        // START with COUNT=0 is ignored
        wr(A_CTRL, 8'h10);
        check("pol_off_uo", uo_out, 8'h00);
        wr(A_COUNT, 8'd0);
        wr(A_CTRL, 8'h01);
        check_rd("zero_count_ctrl", A_CTRL, 8'h00);
        check("zero_count_uo", uo_out, 8'h00);

        // Writes to REMAIN and undefined addresses change nothing
        wr(A_REMAIN, 8'h5A);
        check_rd("remain_ro", A_REMAIN, 8'h00);
        wr(4'h9, 8'hFF);
        check_rd("undef_rd", 4'h9, 8'h00);
        check_rd("undef_pins", A_PINS, 8'h01);

        // START while busy must not restart the phase or REMAIN
        wr(A_COUNT, 8'd3);
        wr(A_HIGH, 8'd4);
        wr(A_LOW, 8'd4);
        wr(A_CTRL, 8'h01);
        wr(A_CTRL, 8'h01);
        check_rd("rebusy_remain", A_REMAIN, 8'd3);
        step(2);
        check("rebusy_e3_uo", uo_out, 8'h01);
        step(1);
        check("rebusy_e4_uo", uo_out, 8'h00);
        check_rd("rebusy_e4_remain", A_REMAIN, 8'd3);

        // Asynchronous reset mid-burst, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_uo", uo_out, 8'h00);
        check_rd("arst_ctrl", A_CTRL, 8'h00);
        check_rd("arst_remain", A_REMAIN, 8'h00);
        check_rd("arst_count", A_COUNT, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

`ifdef PULSE_GEN_TRIGGER_EN
        // External trigger, counted by a rising-edge loopback counter
        begin
            int rises;
            logic prev;
            wr(A_CTRL, 8'h08);
            check_rd("trig_en_rd", A_CTRL, 8'h08);
            wr(A_COUNT, 8'd2);
            wr(A_HIGH, 8'd1);
            wr(A_LOW, 8'd1);
            ui_in = 8'h01;
            step(1);
            check("trig_e1_uo", uo_out, 8'h00);
            step(1);
            check("trig_e2_uo", uo_out, 8'h00);
            step(1);
            check("trig_e3_uo", uo_out, 8'h01);
            ui_in = 8'h00;
            rises = 1;
            prev  = uo_out[0];
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (uo_out[0] && !prev) rises++;
                prev = uo_out[0];
            end
            check("trig_rises", 8'(rises), 8'd2);
            check_rd("trig_done", A_CTRL, 8'h48);
        end
`else
        // Without the trigger build, TRIG_EN is not stored and ui_in does nothing
        wr(A_CTRL, 8'h08);
        check_rd("notrig_rd", A_CTRL, 8'h00);
        wr(A_COUNT, 8'd2);
        ui_in = 8'h01;
        step(4);
        check("notrig_uo", uo_out, 8'h00);
        check_rd("notrig_ctrl", A_CTRL, 8'h00);
        ui_in = 8'h00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
